// File: rtl/block_mem_responder.sv
// Block-read memory responder: returns a 4-word aligned block LATENCY edges
// after a read is accepted. Single-word writes are taken only while idle.
module block_mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] address,
  input  logic        Memread,
  input  logic        Memwrite,
  input  logic [31:0] writeData,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] data3,
  output logic [31:0] data4,
  output logic        ready,
  output logic        busy,
  output logic [15:0] rd_count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [31:0] mem_t [DEPTH];
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic mem_t f_preload();
    for (int i = 0; i < DEPTH; i++) f_preload[i] = i[31:0];
  endfunction

  // Contents come up as word[i] = i and are never touched by reset.
  mem_t        r_mem = f_preload();
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [AW-3:0] r_blk;
  logic [31:0] r_data [4];
  logic [15:0] r_rd_count;
  logic        w_accept, w_write;

  // A simultaneous write wins; the read is picked up on a later edge.
  assign w_write  = (r_state == IDLE) && Memwrite;
  assign w_accept = (r_state == IDLE) && Memread && !Memwrite;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == RESP);
    busy  = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_blk      <= '0;
      r_rd_count <= 16'd0;
      for (int k = 0; k < 4; k++) r_data[k] <= 32'd0;
    end else begin
      if (w_accept) begin
        r_blk <= address[AW-1:2];
        r_cnt <= 4'(LATENCY - 1);
      end
      if (r_state == WAIT) begin
        if (r_cnt == 4'd0) begin
          for (int k = 0; k < 4; k++) r_data[k] <= r_mem[{r_blk, 2'(k)}];
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      if (r_state == RESP) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_write) r_mem[address[AW-1:0]] <= writeData;
  end

  assign data1    = r_data[0];
  assign data2    = r_data[1];
  assign data3    = r_data[2];
  assign data4    = r_data[3];
  assign rd_count = r_rd_count;

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder with LATENCY=4.
module tb_block_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] address;
  logic        Memread, Memwrite;
  logic [31:0] writeData;
  logic [31:0] data1, data2, data3, data4;
  logic        ready, busy;
  logic [15:0] rd_count;

  int checks = 0;
  int errors = 0;
  int n;
  int pulses, busy_low;

  block_mem_responder #(.LATENCY(4), .DEPTH(32768)) dut (
    .clk(clk), .reset(reset), .address(address), .Memread(Memread),
    .Memwrite(Memwrite), .writeData(writeData), .data1(data1), .data2(data2),
    .data3(data3), .data4(data4), .ready(ready), .busy(busy), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic chk_block(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] e4);
    chk({tag, "_d1"}, data1, e1);
    chk({tag, "_d2"}, data2, e2);
    chk({tag, "_d3"}, data3, e3);
    chk({tag, "_d4"}, data4, e4);
  endtask

  initial begin
    reset = 1'b1; address = '0; Memread = 1'b0; Memwrite = 1'b0; writeData = '0;
    @(negedge clk);
    step(); step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(rd_count), 32'd0);
    chk_block("rst", 0, 0, 0, 0);

    // Basic read of block 1024
    reset = 1'b0; Memread = 1'b1; address = 15'd1024;
    step();
    Memread = 1'b0;
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_ready", 32'(ready), 32'd0);
    wait_ready(n);
    chk("lat_1024", 32'(n), 32'd4);
    chk_block("rd1024", 1024, 1025, 1026, 1027);
    step();
    chk("post_ready", 32'(ready), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("count1", 32'(rd_count), 32'd1);

    // Write then read the containing block
    Memwrite = 1'b1; address = 15'd5; writeData = 32'hDEADBEEF;
    step();
    chk("wr_busy", 32'(busy), 32'd0);
    Memwrite = 1'b0; Memread = 1'b1; address = 15'd6;
    step();
    Memread = 1'b0;
    wait_ready(n);
    chk("lat_6", 32'(n), 32'd4);
    chk_block("rd6", 4, 32'hDEADBEEF, 6, 7);
    step();
    chk("count2", 32'(rd_count), 32'd2);

    // Held Memread: three back-to-back reads at address 0
    Memread = 1'b1; address = 15'd0;
    pulses = 0; busy_low = 0;
    for (int s = 1; s <= 18; s++) begin
      step();
      if (ready === 1'b1) begin
        pulses++;
        chk("pulse_pos", 32'(s), 32'(6 * pulses - 1));
      end
      if (s < 18 && busy === 1'b0) busy_low++;
    end
    Memread = 1'b0;
    chk("pulses", 32'(pulses), 32'd3);
    chk("busy_gaps", 32'(busy_low), 32'd2);
    chk("end_busy", 32'(busy), 32'd0);
    chk("count5", 32'(rd_count), 32'd5);
    chk_block("rd0", 0, 1, 2, 3);

    // Simultaneous read and write: write first, read next edge
    Memread = 1'b1; Memwrite = 1'b1; address = 15'd8; writeData = 32'h55;
    step();
    chk("rw_busy", 32'(busy), 32'd0);
    Memwrite = 1'b0;
    step();
    chk("rw_acc", 32'(busy), 32'd1);
    Memread = 1'b0;
    wait_ready(n);
    chk("lat_8", 32'(n), 32'd4);
    chk_block("rd8", 32'h55, 9, 10, 11);
    step();
    chk("count6", 32'(rd_count), 32'd6);

    // Write during WAIT into the in-flight block is dropped
    Memread = 1'b1; address = 15'd12;
    step();
    Memread = 1'b0; Memwrite = 1'b1; address = 15'd13; writeData = 32'hAAAA;
    step();
    Memwrite = 1'b0;
    wait_ready(n);
    chk_block("rd12a", 12, 13, 14, 15);
    step();
    Memread = 1'b1; address = 15'd12;
    step();
    Memread = 1'b0;
    wait_ready(n);
    chk_block("rd12b", 12, 13, 14, 15);
    step();
    chk("count8", 32'(rd_count), 32'd8);

    // Reset two cycles into WAIT, with a read request present at the reset edge
    Memread = 1'b1; address = 15'd20;
    step();
    Memread = 1'b0;
    step(); step();
    reset = 1'b1; Memread = 1'b1;
    step();
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ready", 32'(ready), 32'd0);
    chk("ab_count", 32'(rd_count), 32'd0);
    chk_block("ab", 0, 0, 0, 0);
    Memread = 1'b0;
    pulses = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (ready === 1'b1) pulses++;
    end
    chk("ab_nopulse", 32'(pulses), 32'd0);

    // First request after reset release
    reset = 1'b0; Memread = 1'b1; address = 15'd20;
    step();
    chk("rel_busy", 32'(busy), 32'd1);
    Memread = 1'b0;
    wait_ready(n);
    chk("lat_20", 32'(n), 32'd4);
    chk_block("rd20", 20, 21, 22, 23);
    step();
    chk("count_rel", 32'(rd_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
